// File: rtl/n_bit_universal_shiftregister.sv
// Universal shift register: hold, shift, rotate, arithmetic shift and parallel load.
// Optional shift counter with done flag, enabled by defining SHIFTREG_COUNT_EN.
module n_bit_universal_shiftregister #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in,
  input  logic             rightshift,
  input  logic             leftshift,
  output logic [WIDTH-1:0] out,
  output logic             so_r,
  output logic             so_l,
  output logic [CNTW-1:0]  cnt,
  output logic             done
);

  logic [WIDTH-1:0] out_nxt;

  always_comb begin
    out_nxt = out;
    case (sel)
      3'b001:  out_nxt = {rightshift, out[WIDTH-1:1]};
      3'b010:  out_nxt = {out[WIDTH-2:0], leftshift};
      3'b011:  out_nxt = in;
      3'b100:  out_nxt = {out[0], out[WIDTH-1:1]};
      3'b101:  out_nxt = {out[WIDTH-2:0], out[WIDTH-1]};
      3'b110:  out_nxt = {out[WIDTH-1], out[WIDTH-1:1]};
      default: out_nxt = out;
    endcase
  end

  // stage p0: register contents
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      out <= '0;
    end else if (en) begin
      out <= out_nxt;
    end
  end

  assign so_r = out[0];
  assign so_l = out[WIDTH-1];

`ifdef SHIFTREG_COUNT_EN
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);

  logic            shift_op;
  logic [CNTW-1:0] cnt_p0;

  always_comb begin
    shift_op = 1'b0;
    case (sel)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: shift_op = 1'b1;
      default:                                shift_op = 1'b0;
    endcase
  end

  // stage p0: shifts since last load, saturating so done stays asserted
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_p0 <= '0;
    end else if (en) begin
      if (sel == 3'b011) begin
        cnt_p0 <= '0;
      end else if (shift_op && (cnt_p0 != CNT_MAX)) begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  assign cnt  = cnt_p0;
  assign done = (cnt_p0 == CNT_MAX);
`else
  assign cnt  = '0;
  assign done = 1'b0;
`endif

endmodule

// File: doc/n_bit_universal_shiftregister.md
N_BIT_UNIVERSAL_SHIFTREGISTER -- requirements
Module: n_bit_universal_shiftregister

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter CNTW, default $clog2(WIDTH+1), shift-counter width.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port sync_reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  operation enable; when low, all state SHALL hold.
REQ-006 Port sel  input  3  mode select (see REQ-011).
REQ-007 Port in  input  WIDTH  parallel load data.
REQ-008 Port rightshift  input  1  serial input entering at out[WIDTH-1] on shift right.
REQ-009 Port leftshift  input  1  serial input entering at out[0] on shift left.
REQ-010 Ports out (output, WIDTH, register contents); so_r (output, 1, out[0]); so_l (output, 1, out[WIDTH-1]); cnt (output, CNTW, shifts since load); done (output, 1, cnt==WIDTH).

Function
REQ-011 When en=1, the sel encoding SHALL be:
- 000 hold
- 001 shift right: out <= {rightshift, out[WIDTH-1:1]}
- 010 shift left: out <= {out[WIDTH-2:0], leftshift}
- 011 parallel load: out <= in
- 100 rotate right: out <= {out[0], out[WIDTH-1:1]}
- 101 rotate left: out <= {out[WIDTH-2:0], out[WIDTH-1]}
- 110 arithmetic shift right: out <= {out[WIDTH-1], out[WIDTH-1:1]}
- 111 reserved; SHALL behave as hold.
REQ-012 Every operation SHALL have single-cycle latency: the result SHALL be visible on out in the cycle after the capturing edge.
REQ-013 so_r and so_l SHALL be combinational taps of the current out register, with no extra latency.
REQ-014 Shift/rotate classes: sel in {001, 010, 100, 101, 110} with en=1 is a "shift op".
REQ-015 cnt SHALL clear to 0 on a parallel load (sel=011, en=1).
REQ-016 cnt SHALL increment by 1 on each shift op, and SHALL saturate at WIDTH without wrapping.
REQ-017 cnt SHALL hold on hold, reserved, or en=0.
REQ-018 done SHALL be combinational, equal to (cnt == WIDTH).
REQ-019 Shift ops SHALL continue to modify out after done=1; only cnt saturates.
REQ-020 A load in the same cycle that done=1 SHALL clear cnt, so that done=0 on the next cycle.
REQ-021 X or unknown sel values are not supported; the behaviour for reserved encodings is defined solely by REQ-011.

Reset
REQ-022 When sync_reset=1 at a rising clk edge, out and cnt SHALL become 0 regardless of en and sel.
- Consequently so_r=0, so_l=0, and done=0.
REQ-023 sync_reset SHALL take priority over every mode, including a load in the same cycle.
REQ-024 Asserting reset mid-serialisation SHALL abandon the operation; no partial state SHALL survive.
REQ-025 The block SHALL have no asynchronous reset path; between clock edges, sync_reset SHALL have no effect.

Configuration
REQ-026 Macro SHIFTREG_COUNT_EN: when defined, the shift counter and done logic SHALL be implemented per REQ-015..REQ-020.
REQ-027 When SHIFTREG_COUNT_EN is undefined:
- The cnt and done ports SHALL remain present and be tied to constant 0.
- No counter flops SHALL be inferred.
- All other behaviour SHALL be unchanged.

Verification (WIDTH=8, SHIFTREG_COUNT_EN defined unless stated)
REQ-028 Load in=8'hA5 with sel=011 -> next cycle out=8'hA5, cnt=0, done=0, so_r=1, so_l=1.
REQ-029 From out=8'hA5, eight shift-rights with rightshift=0 -> out sequence 52,29,14,0A,05,02,01,00; cnt=8, done=1; a ninth shift leaves cnt=8.
REQ-030 From out=8'h81:
- rotate left -> 8'h03
- rotate right twice from 8'h81 -> 8'h60
- arithmetic shift right from 8'h81 -> 8'hC0
REQ-031 From out=8'h3C:
- shift left with leftshift=1 -> 8'h79
- en=0 with sel=010 for 3 cycles -> out holds 8'h79 and cnt holds.
- sel=111 -> out holds.
REQ-032 Set cnt=5, then assert sync_reset together with sel=011 and in=8'hFF -> out=0, cnt=0, done=0; the next cycle's load is accepted normally.
REQ-033 Without SHIFTREG_COUNT_EN, repeat REQ-029 -> out values are identical, while cnt=0 and done=0 throughout.
